dp_ram_arbiter: RTL

- Round-robin arbiter and command sequencer that shares one dual-port RAM port among NUM_REQ requesters.
- Grants bursts, muxes each granted requester's command onto the registered RAM port, and routes read data back to the issuing requester after the RAM read latency.
- Sits between client engines and the dp_ram storage port.

---
 rtl/dp_ram_arb_pkg.sv | 36 +++
 rtl/dp_ram_arb_if.sv | 33 +++
 rtl/dp_ram_arb_rdpipe.sv | 49 ++++
 rtl/dp_ram_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_arb_pkg.sv
// Shared types, constants and the round-robin pick helper for dp_ram_arbiter.
package dp_ram_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of each per-requester transfer counter (optional statistics).
  localparam int STAT_W  = 16;
  // Largest supported requester count; the pick helper works at this width.
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  // One-hot first set bit of req, searching upward from ptr with wrap.
  // Callers zero-extend narrower request vectors. The unused upper bits are
  // never set, so wrapping at MAX_REQ visits requesters in the same order as
  // wrapping at the real requester count.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [MAX_REQ-1:0] pick;
    logic [PTR_W-1:0]   idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + PTR_W'(k);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dp_ram_arb_if.sv
// Client and RAM-side bus of the dp_ram_arbiter.
// slave  : the arbiter's view (takes requests, drives grants and the RAM port)
// master : the clients' and RAM's view
interface dp_ram_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic                      ram_en;
  logic                      ram_we;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_wdata;
  logic [DATA_W-1:0]         ram_rdata;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;

  modport slave (
    input  req, we, addr, wdata, ram_rdata,
    output gnt, ram_en, ram_we, ram_addr, ram_wdata, rd_valid, rd_data
  );

  modport master (
    output req, we, addr, wdata, ram_rdata,
    input  gnt, ram_en, ram_we, ram_addr, ram_wdata, rd_valid, rd_data
  );

endinterface

// File: rtl/dp_ram_arb_rdpipe.sv
// Read-return tracker: carries {valid, one-hot requester id} alongside the
// RAM read latency so returning data can be steered to its issuer.
// A synchronous active-low clear drops every read still in flight.
module dp_ram_arb_rdpipe #(
  parameter int NUM_REQ = 4,
  parameter int RD_LAT  = 1
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               in_vld,
  input  logic [NUM_REQ-1:0] in_id,
  output logic               out_vld,
  output logic [NUM_REQ-1:0] out_id
);

  typedef struct packed {
    logic               vld;
    logic [NUM_REQ-1:0] id;
  } slot_t;

  slot_t pipe_q [RD_LAT];
  slot_t pipe_d [RD_LAT];

  // Shift the read tags one stage per cycle; idle slots carry a zero id.
  always_comb begin
    pipe_d[0].vld = in_vld;
    pipe_d[0].id  = in_vld ? in_id : '0;
    for (int s = 1; s < RD_LAT; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  // Pipeline state, cleared together with the arbiter.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_q[s] <= pipe_d[s];
      end
    end
  end

  assign out_vld = pipe_q[RD_LAT-1].vld;
  assign out_id  = pipe_q[RD_LAT-1].id;

endmodule

// File: rtl/dp_ram_arbiter.sv
// Round-robin burst arbiter sharing one RAM port among NUM_REQ requesters.
// The granted requester's command is registered onto the RAM port and read
// data is steered back to its issuer RD_LAT cycles after the RAM strobe.
// Optional per-requester transfer counters: define DP_RAM_ARB_STATS_EN.
module dp_ram_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
`ifdef DP_RAM_ARB_STATS_EN
  input  logic                      stat_clear,
  output logic [NUM_REQ*STAT_W-1:0] stat_cnt,
`endif
  dp_ram_arb_if.slave               bus
);

  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(MAX_BURST - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               ram_en_q, ram_en_d;
  logic               ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic [NUM_REQ-1:0] ram_id_q, ram_id_d;

  logic               xfer;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  logic               ret_vld;
  logic [NUM_REQ-1:0] ret_id;

  // Decode the current grant: transfer strobe, granted index and its command.
  always_comb begin
    xfer      = (state_q == GRANT) && (|(gnt_q & bus.req));
    gnt_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        gnt_idx = PTR_W'(i);
      end
      sel_we    = sel_we    | (bus.we[i] & gnt_q[i]);
      sel_addr  = sel_addr  | (bus.addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{gnt_q[i]}});
      sel_wdata = sel_wdata | (bus.wdata[i*DATA_W +: DATA_W] & {DATA_W{gnt_q[i]}});
    end
    next_ptr = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  // Arbitration FSM next state plus the registered RAM command.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    burst_d     = burst_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_id_d    = '0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = NUM_REQ'(rr_pick(MAX_REQ'(bus.req), ptr_q));
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          ram_en_d    = 1'b1;
          ram_we_d    = sel_we;
          ram_addr_d  = sel_addr;
          ram_wdata_d = sel_wdata;
          ram_id_d    = gnt_q;
        end
        // Release on a dropped request or after the last beat of a burst;
        // the following IDLE cycle is the mandatory bubble between grants.
        if (!xfer || (burst_q == LAST_BEAT)) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr;
          burst_d = '0;
        end else begin
          burst_d = burst_q + BURST_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Control and RAM-port registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ptr_q       <= '0;
      burst_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      burst_q     <= burst_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_id_q    <= ram_id_d;
    end
  end

  // Reads are tagged at the RAM strobe; the tag emerges as the data arrives.
  dp_ram_arb_rdpipe #(
    .NUM_REQ (NUM_REQ),
    .RD_LAT  (RD_LAT)
  ) u_rdpipe (
    .clock   (clock),
    .clear_n (reset_n),
    .in_vld  (ram_en_q & ~ram_we_q),
    .in_id   (ram_id_q),
    .out_vld (ret_vld),
    .out_id  (ret_id)
  );

  assign bus.gnt       = gnt_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.rd_valid  = ret_vld ? ret_id : '0;
  assign bus.rd_data   = ret_vld ? bus.ram_rdata : '0;

`ifdef DP_RAM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];
  logic [STAT_W-1:0] stat_d [NUM_REQ];

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  // Per-requester transfer count; a clear overrides a coincident transfer.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clear) begin
        stat_d[i] = '0;
      end else if (xfer && gnt_q[i]) begin
        stat_d[i] = sat_inc(stat_q[i]);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end

  // Pack the counters, requester i at [i*STAT_W +: STAT_W].
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_cnt[i*STAT_W +: STAT_W] = stat_q[i];
    end
  end
`endif

endmodule
